rv32_alu_issue: RTL and testbench

- Issue/operand-fetch stage directly upstream of rv32_alu_fsm in the multicycle RV32 core.
- Accepts one instruction at a time and reads rs1/rs2 from a registered single-read-port register file.
- Forms operands and the ALU select, then drives the ALU FSM and waits for its data-valid, with a timeout.
- Writes the result back to rd and reports retire, illegal and timeout status.

---
 rtl/rv32_alu_issue.sv | 122 ++++++++++++
 tb/tb_rv32_alu_issue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_alu_issue.sv
// rv32_alu_issue: issue/operand-fetch stage feeding the multicycle ALU FSM.
// Reads rs1/rs2 through a one-cycle-latency register file port, runs the ALU with a timeout, writes back rd.
module rv32_alu_issue #(
    parameter int TIMEOUT_CYCLES = 8,
    parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [31:0] i_instr,
    output logic [4:0]  o_rf_raddr,
    input  logic [31:0] i_rf_rdata,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic [31:0] o_alu_operand_one,
    output logic [31:0] o_alu_operand_two,
    output logic [1:0]  o_alu_sel,
    output logic        o_alu_start,
    input  logic        i_alu_data_valid,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_carry_out,
    output logic        o_carry_flag,
    output logic        o_retired,
    output logic        o_illegal,
    output logic        o_timeout,
    output logic        o_busy
);
    localparam logic [2:0] IDLE = 3'd0, READ_RS1 = 3'd1, READ_RS2 = 3'd2,
                           LATCH = 3'd3, EXEC = 3'd4, WB = 3'd5;
    logic [2:0] state;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] imm, op_one, op_two, result;
    logic [1:0] sel;
    logic is_r, carry, illegal, timeout;
    logic [CNT_W-1:0] cnt;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic dec_r, dec_i, accept, valid_ok, last;
    logic [1:0] dec_sel;
    assign opc = i_instr[6:0];
    assign f3 = i_instr[14:12];
    assign f7 = i_instr[31:25];
    assign dec_r = opc == 7'b0110011 &&
                   ((f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000)) ||
                    ((f3 == 3'b110 || f3 == 3'b111) && f7 == 7'b0000000));
    assign dec_i = opc == 7'b0010011 && (f3 == 3'b000 || f3 == 3'b110 || f3 == 3'b111);
    assign dec_sel = f3 == 3'b000 ? {1'b0, dec_r & f7[5]} : f3 == 3'b111 ? 2'b10 : 2'b11;
    assign accept = i_instr_valid && state == IDLE;
    // A valid seen in the first EXEC cycle may be left over from the previous op
    assign valid_ok = i_alu_data_valid && cnt != '0;
    assign last = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            rs1 <= '0;
            rs2 <= '0;
            rd <= '0;
            imm <= '0;
            sel <= '0;
            is_r <= 1'b0;
            op_one <= '0;
            op_two <= '0;
            result <= '0;
            carry <= 1'b0;
            cnt <= '0;
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            illegal <= accept && !(dec_r || dec_i);
            case (state)
                IDLE: if (accept && (dec_r || dec_i)) begin
                    rs1 <= i_instr[19:15];
                    rs2 <= i_instr[24:20];
                    rd <= i_instr[11:7];
                    imm <= {{20{i_instr[31]}}, i_instr[31:20]};
                    sel <= dec_sel;
                    is_r <= dec_r;
                    state <= READ_RS1;
                end
                READ_RS1: state <= is_r ? READ_RS2 : LATCH;
                READ_RS2: begin
                    op_one <= i_rf_rdata;
                    state <= LATCH;
                end
                LATCH: begin
                    op_one <= is_r ? op_one : i_rf_rdata;
                    op_two <= is_r ? i_rf_rdata : imm;
                    cnt <= '0;
                    state <= EXEC;
                end
                EXEC: begin
                    cnt <= cnt + 1'b1;
                    if (valid_ok) begin
                        result <= i_alu_result;
                        carry <= i_alu_carry_out;
                        state <= WB;
                    end else if (last) begin
                        timeout <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign o_instr_ready = state == IDLE;
    assign o_busy = state != IDLE;
    assign o_alu_start = state == EXEC;
    assign o_retired = state == WB;
    assign o_rf_we = state == WB && rd != 5'd0;
    assign o_rf_waddr = rd;
    assign o_rf_wdata = result;
    assign o_rf_raddr = state == READ_RS1 ? rs1 : state == READ_RS2 ? rs2 : 5'd0;
    assign o_alu_operand_one = op_one;
    assign o_alu_operand_two = op_two;
    assign o_alu_sel = sel;
    assign o_carry_flag = carry;
    assign o_illegal = illegal;
    assign o_timeout = timeout;
endmodule

// File: tb/tb_rv32_alu_issue.sv
// tb_rv32_alu_issue: directed vectors with a scoreboard of expected retire/illegal/timeout events.
module tb_rv32_alu_issue;
    logic clk = 1'b0, rst = 1'b0;
    logic instr_valid = 1'b0, instr_ready;
    logic [31:0] instr = '0;
    logic [4:0] rf_raddr, rf_waddr;
    logic [31:0] rf_rdata, rf_wdata;
    logic rf_we;
    logic [31:0] op_one, op_two, alu_res;
    logic [1:0] alu_sel;
    logic alu_start, alu_valid, alu_carry;
    logic carry_flag, retired, illegal, timeout, busy;
    logic [31:0] regs [32];
    logic [7:0] exec_cyc, alu_lat;
    logic tprev;
    int checks = 0, errors = 0;
    typedef struct packed {
        logic [1:0] kind;
        logic we;
        logic [4:0] waddr;
        logic [31:0] wdata;
        logic carry;
    } ev_t;
    ev_t q[$];

    rv32_alu_issue dut (
        .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
        .i_instr(instr), .o_rf_raddr(rf_raddr), .i_rf_rdata(rf_rdata), .o_rf_we(rf_we),
        .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata), .o_alu_operand_one(op_one),
        .o_alu_operand_two(op_two), .o_alu_sel(alu_sel), .o_alu_start(alu_start),
        .i_alu_data_valid(alu_valid), .i_alu_result(alu_res), .i_alu_carry_out(alu_carry),
        .o_carry_flag(carry_flag), .o_retired(retired), .o_illegal(illegal),
        .o_timeout(timeout), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rf_rdata <= regs[rf_raddr];

    // ALU stand-in: answers exec_cyc == alu_lat cycles into EXEC (0 = stale-valid only)
    always_ff @(posedge clk) exec_cyc <= alu_start ? exec_cyc + 8'd1 : 8'd0;
    always_comb begin
        alu_valid = alu_start && exec_cyc == alu_lat;
        {alu_carry, alu_res} = alu_sel == 2'b00 ? {1'b0, op_one} + {1'b0, op_two} :
                               alu_sel == 2'b01 ? {1'b0, op_one} + {1'b0, ~op_two} + 33'd1 :
                               alu_sel == 2'b10 ? {1'b0, op_one & op_two} : {1'b0, op_one | op_two};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_ret(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic c);
        q.push_back('{kind: 2'd0, we: we, waddr: wa, wdata: wd, carry: c});
    endtask

    task automatic exp_kind(input logic [1:0] k);
        q.push_back('{kind: k, we: 1'b0, waddr: 5'd0, wdata: 32'd0, carry: 1'b0});
    endtask

    always @(negedge clk) begin
        tprev <= timeout;
        if (!rst) begin
            if (rf_we && !retired) chk("we_outside_wb", 32'(rf_we), 32'd0);
            if (retired || illegal || (timeout && !tprev)) begin
                if (q.size() == 0) chk("unexpected_event", {29'd0, retired, illegal, timeout}, 32'd0);
                else begin
                    chk("event_kind", 32'(q[0].kind), retired ? 32'd0 : illegal ? 32'd1 : 32'd2);
                    if (retired) begin
                        chk("rf_we", 32'(rf_we), 32'(q[0].we));
                        if (q[0].we) begin
                            chk("rf_waddr", 32'(rf_waddr), 32'(q[0].waddr));
                            chk("rf_wdata", rf_wdata, q[0].wdata);
                        end
                        chk("carry_flag", 32'(carry_flag), 32'(q[0].carry));
                    end
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic accept(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr = w;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic wait_exec(output int lat);
        lat = 0;
        while (!alu_start && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("returns_idle", 32'(busy), 32'd0);
    endtask

    task automatic run(input logic [31:0] w, input int exp_lat, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [1:0] es);
        int lat;
        accept(w);
        wait_exec(lat);
        chk("exec_latency", 32'(lat), 32'(exp_lat));
        chk("op_one", op_one, e1);
        chk("op_two", op_two, e2);
        chk("alu_sel", 32'(alu_sel), 32'(es));
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        alu_lat = 8'd255;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(alu_start), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_flags", {28'd0, retired, illegal, timeout, carry_flag}, 32'd0);
        chk("rst_ops", op_one | op_two, 32'd0);
        rst = 1'b0;

        // asynchronous reset in the middle of EXEC
        accept(32'h002081B3);
        wait_exec(lat);
        chk("midexec_start", 32'(alu_start), 32'd1);
        chk("midexec_op_one", op_one, 32'd5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_start", 32'(alu_start), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_we", 32'(rf_we), 32'd0);
        chk("async_ready", 32'(instr_ready), 32'd1);
        chk("async_ops", op_one | op_two, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD x3,x1,x2
        alu_lat = 8'd3;
        exp_ret(1'b1, 5'd3, 32'h0000_000C, 1'b0);
        run(32'h002081B3, 3, 32'd5, 32'd7, 2'b00);

        // ADDI x4,x1,-1 with valid on the earliest accepted cycle
        regs[1] = 32'd0;
        alu_lat = 8'd1;
        exp_ret(1'b1, 5'd4, 32'hFFFF_FFFF, 1'b0);
        run(32'hFFF08213, 2, 32'd0, 32'hFFFF_FFFF, 2'b00);

        // SUB x0,x1,x2: retires with no write, carry (no borrow) = 1
        regs[1] = 32'd9;
        alu_lat = 8'd2;
        exp_ret(1'b0, 5'd0, 32'd0, 1'b1);
        run(32'h40208033, 3, 32'd9, 32'd7, 2'b01);

        // OR / AND / ORI (valid on the last allowed EXEC cycle)
        regs[1] = 32'hF0F0_0F0F;
        regs[2] = 32'h0FF0_00FF;
        exp_ret(1'b1, 5'd5, 32'hFFF0_0FFF, 1'b0);
        run(32'h0020E2B3, 3, 32'hF0F0_0F0F, 32'h0FF0_00FF, 2'b11);
        exp_ret(1'b1, 5'd6, 32'h00F0_000F, 1'b0);
        run(32'h0020F333, 3, 32'hF0F0_0F0F, 32'h0FF0_00FF, 2'b10);
        alu_lat = 8'd7;
        exp_ret(1'b1, 5'd7, 32'hF0F0_0FFF, 1'b0);
        run(32'h7FF0E393, 2, 32'hF0F0_0F0F, 32'h0000_07FF, 2'b11);
        chk("no_timeout_yet", 32'(timeout), 32'd0);

        // illegal words: bad opcode, then ADD with a bad funct7
        exp_kind(2'd1);
        accept(32'h0000007F);
        chk("illegal_busy", 32'(busy), 32'd0);
        chk("illegal_raddr", 32'(rf_raddr), 32'd0);
        @(posedge clk);
        #1;
        chk("illegal_one_cycle", 32'(illegal), 32'd0);
        chk("illegal_stays_idle", 32'(busy), 32'd0);
        exp_kind(2'd1);
        accept(32'h022081B3);
        chk("illegal2_busy", 32'(busy), 32'd0);

        // stale valid in first EXEC cycle only -> timeout after 8 EXEC cycles
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        alu_lat = 8'd0;
        exp_kind(2'd2);
        accept(32'h002081B3);
        wait_exec(lat);
        n = 1;
        while (alu_start && n < 20) begin
            @(posedge clk);
            #1;
            if (alu_start) n++;
        end
        chk("timeout_exec_cycles", 32'(n), 32'd8);
        chk("timeout_set", 32'(timeout), 32'd1);
        chk("timeout_idle", 32'(busy), 32'd0);

        // issue still works after a timeout; flag stays sticky
        alu_lat = 8'd2;
        exp_ret(1'b1, 5'd3, 32'h0000_000C, 1'b0);
        run(32'h002081B3, 3, 32'd5, 32'd7, 2'b00);
        chk("timeout_sticky", 32'(timeout), 32'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
